// File: rtl/mul_issue_ctrl.sv
// Operand-issue controller for a sequential signed multiplier: FIFO-buffered operand pairs, one operation at a time, ordered result register.
// Optional zero-operand bypass (result 0 without starting the multiplier) enabled by defining MUL_ISSUE_ZERO_BYPASS_EN.
module mul_issue_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     in_ready,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_ready,
  input  logic [2*WIDTH-1:0]       mul_product,
  output logic                     res_valid,
  output logic [2*WIDTH-1:0]       res_product,
  input  logic                     res_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] fifo_a [DEPTH];
  logic [WIDTH-1:0] fifo_b [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             slot_free;
  logic             head_zero;
  logic             bypass;
  logic             issue_go;
  logic             capture;

  assign full      = (level == LVL_FULL);
  assign empty     = (level == '0);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign head_a    = fifo_a[rd_ptr];
  assign head_b    = fifo_b[rd_ptr];
  assign slot_free = !res_valid || res_ready;

`ifdef MUL_ISSUE_ZERO_BYPASS_EN
  assign head_zero = (head_a == '0) || (head_b == '0);
`else
  assign head_zero = 1'b0;
`endif

  // A zero-operand head with the slot occupied simply takes the normal multiplier path.
  assign bypass   = (state == IDLE) && !empty && head_zero && slot_free;
  assign issue_go = (state == IDLE) && !empty && mul_ready && !bypass;
  assign pop      = bypass || issue_go;
  assign capture  = (state == WAIT_DONE) && mul_ready && slot_free;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= in_a;
      fifo_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mul_start   <= 1'b0;
      busy        <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      res_valid   <= 1'b0;
      res_product <= '0;
    end else begin
      case (state)
        IDLE: begin
          mul_start <= 1'b0;
          if (issue_go) begin
            mul_a     <= head_a;
            mul_b     <= head_b;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mul_start <= 1'b0;
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!mul_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (capture) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          mul_start <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase

      if (capture) begin
        res_product <= mul_product;
        res_valid   <= 1'b1;
      end else if (bypass) begin
        res_product <= '0;
        res_valid   <= 1'b1;
      end else if (res_ready) begin
        res_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: behavioural sequential multiplier plus an in-order result scoreboard.
module tb_mul_issue_ctrl;
  localparam int W   = 16;
  localparam int D   = 4;
  localparam int LAT = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic [W-1:0]         in_a = '0;
  logic [W-1:0]         in_b = '0;
  logic                 in_ready;
  logic                 mul_start;
  logic [W-1:0]         mul_a;
  logic [W-1:0]         mul_b;
  logic                 mul_ready;
  logic [2*W-1:0]       mul_product;
  logic                 res_valid;
  logic [2*W-1:0]       res_product;
  logic                 res_ready = 1'b0;
  logic                 busy;
  logic [$clog2(D):0]   level;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int res_cnt = 0;
  logic signed [2*W-1:0] exp_q[$];

  mul_issue_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_product(mul_product),
    .res_valid(res_valid), .res_product(res_product), .res_ready(res_ready),
    .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  // Sequential multiplier model: drops ready after start, returns it LAT+1 cycles later.
  int                    mcnt;
  logic signed [2*W-1:0] mprod;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_ready <= 1'b1;
      mcnt      <= 0;
      mprod     <= '0;
    end else if (mul_start) begin
      mul_ready <= 1'b0;
      mcnt      <= LAT;
      mprod     <= $signed(mul_a) * $signed(mul_b);
    end else if (!mul_ready) begin
      if (mcnt == 0) mul_ready <= 1'b1;
      else mcnt <= mcnt - 1;
    end
  end
  assign mul_product = mprod;

  always @(negedge clk) begin
    if (rst && mul_start) begin
      start_cnt++;
      if (!busy) begin
        errors++;
        $display("FAIL start_while_idle: mul_start=1 busy=%0b required busy=1", busy);
      end
    end
  end

  always @(negedge clk) begin
    logic signed [2*W-1:0] e;
    if (rst && res_valid && res_ready) begin
      res_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got %0d with empty scoreboard", $signed(res_product));
      end else begin
        e = exp_q.pop_front();
        if (res_product !== e) begin
          errors++;
          $display("FAIL result_order: got %0d required %0d", $signed(res_product), e);
        end
      end
    end
  end

  task automatic push_pair(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic signed [2*W-1:0] p;
    bit ok = 0;
    int n = 0;
    p = a * b;
    exp_q.push_back(p);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!ok && n < 500) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout: pair (%0d,%0d) not accepted", a, b);
    end
  endtask

  task automatic drain();
    bit done = 0;
    int n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !res_valid && !busy && level == 0) done = 1;
      n++;
    end
    @(posedge clk); #1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d res_valid=%0b busy=%0b level=%0d required empty/idle",
               exp_q.size(), res_valid, busy, level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, mul_start, mul_a, mul_b, res_valid, res_product, busy, level} !==
        {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, {2*W{1'b0}}, 1'b0, {($clog2(D)+1){1'b0}}}) begin
      errors++;
      $display("FAIL reset_values: in_ready=%0b start=%0b a=%0d b=%0d rv=%0b rp=%0d busy=%0b level=%0d required 1,0,0,0,0,0,0,0",
               in_ready, mul_start, mul_a, mul_b, res_valid, res_product, busy, level);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%0b busy=%0b required 1 0", in_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int s0 = start_cnt;
    int r0 = res_cnt;
    res_ready = 1'b1;
    push_pair(16'sd12345, -16'sd1);
    @(negedge clk);
    checks++;
    if (mul_start !== 1'b0 || level !== 1) begin
      errors++;
      $display("FAIL issue_latency_pre: mul_start=%0b level=%0d required 0 1", mul_start, level);
    end
    @(negedge clk);
    checks++;
    if (mul_start !== 1'b1 || $signed(mul_a) !== 16'sd12345 || $signed(mul_b) !== -16'sd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL issue_latency: mul_start=%0b a=%0d b=%0d busy=%0b required 1 12345 -1 1",
               mul_start, $signed(mul_a), $signed(mul_b), busy);
    end
    @(posedge clk); #1;
    drain();
    checks++;
    if (start_cnt - s0 != 1 || res_cnt - r0 != 1 || level !== 0) begin
      errors++;
      $display("FAIL single_op: starts=%0d results=%0d level=%0d required 1 1 0",
               start_cnt - s0, res_cnt - r0, level);
    end
  endtask

  task automatic test_backpressure();
    int r0 = res_cnt;
    res_ready = 1'b0;
    push_pair(16'sd3, 16'sd4);
    push_pair(-16'sd7, 16'sd2);
    push_pair(-16'sd1, 16'sd1);
    push_pair(16'sd100, -16'sd100);
    push_pair(16'sd2, 16'sd2);
    @(negedge clk);
    checks++;
    if (level !== 4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full: level=%0d in_ready=%0b required 4 0", level, in_ready);
    end
    repeat (25) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || $signed(res_product) !== 32'sd12 || level !== 3 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL held_result: rv=%0b rp=%0d level=%0d in_ready=%0b required 1 12 3 1",
               res_valid, $signed(res_product), level, in_ready);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || $signed(res_product) !== 32'sd12) begin
      errors++;
      $display("FAIL result_hold: rv=%0b rp=%0d required 1 12", res_valid, $signed(res_product));
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    drain();
    checks++;
    if (res_cnt - r0 != 5) begin
      errors++;
      $display("FAIL backpressure_count: results=%0d required 5", res_cnt - r0);
    end
  endtask

  task automatic test_zero();
    int s0 = start_cnt;
    res_ready = 1'b1;
    push_pair(16'sd0, 16'sd12345);
    drain();
    checks++;
`ifdef MUL_ISSUE_ZERO_BYPASS_EN
    if (start_cnt - s0 != 0) begin
      errors++;
      $display("FAIL zero_bypass: starts=%0d required 0", start_cnt - s0);
    end
`else
    if (start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL zero_through_mul: starts=%0d required 1", start_cnt - s0);
    end
`endif
  endtask

  task automatic test_extremes();
    int r0 = res_cnt;
    res_ready = 1'b1;
    push_pair(-16'sd32768, -16'sd32768);
    push_pair(-16'sd32768, 16'sd32767);
    drain();
    checks++;
    if (res_cnt - r0 != 2) begin
      errors++;
      $display("FAIL extremes_count: results=%0d required 2", res_cnt - r0);
    end
  endtask

  task automatic test_reset_midop();
    int s0;
    int n = 0;
    res_ready = 1'b1;
    push_pair(16'sd5, 16'sd6);
    push_pair(16'sd7, 16'sd8);
    push_pair(16'sd9, 16'sd10);
    while (mul_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (level !== 2 || busy !== 1'b1 || mul_ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_setup: level=%0d busy=%0b mul_ready=%0b required 2 1 0", level, busy, mul_ready);
    end
    rst = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (level !== 0 || res_valid !== 1'b0 || busy !== 1'b0 || mul_start !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: level=%0d rv=%0b busy=%0b start=%0b required 0 0 0 0",
               level, res_valid, busy, mul_start);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    s0 = start_cnt;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (start_cnt != s0 || level !== 0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_midop_reset: starts=%0d level=%0d rv=%0b busy=%0b required 0 0 0 0",
               start_cnt - s0, level, res_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_zero();
    test_extremes();
    test_reset_midop();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: pending=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

Operand-issue controller upstream of the sequential signed multiplier. Accepts signed operand pairs over a valid/ready stream, buffers them in a small FIFO, drives the multiplier's start/operand inputs one operation at a time, and captures each product into an output register presented over a second valid/ready stream. Results leave in the same order the operand pairs were accepted.

## Interface
- WIDTH, 16, operand width in bits; the product is 2*WIDTH bits.
- DEPTH, 4, operand FIFO entries; must be a power of two, at least 2.
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_a  in  WIDTH  signed multiplicand.
- in_b  in  WIDTH  signed multiplier.
- in_ready  out  1  FIFO can accept a pair; equals !full.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  WIDTH  multiplicand to the multiplier; held stable from ISSUE until capture.
- mul_b  out  WIDTH  multiplier operand; held stable from ISSUE until capture.
- mul_ready  in  1  multiplier idle/done flag.
- mul_product  in  2*WIDTH  multiplier product; valid while mul_ready is high after an operation.
- res_valid  out  1  result register holds an unconsumed product.
- res_product  out  2*WIDTH  signed product.
- res_ready  in  1  downstream accepts the result.
- busy  out  1  high in any state other than IDLE.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FIFO: push on in_valid && in_ready. Pop only from IDLE. No fall-through: a pair pushed in cycle N is visible to the state machine in cycle N+1. Pointers wrap modulo DEPTH. level counts 0..DEPTH.
- States are IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
  - IDLE: if the FIFO is not empty and mul_ready=1, pop the head into the operand registers and go to ISSUE.
  - ISSUE: mul_start=1 for exactly this cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: stay until mul_ready=0, then go to WAIT_DONE.
  - WAIT_DONE: stay until mul_ready=1 and the result slot is free (!res_valid || res_ready). Then load res_product <= mul_product, set res_valid=1, and go to IDLE.
- Result slot:
  - res_valid clears on res_valid && res_ready unless a capture happens in the same cycle.
  - A capture and a consume in the same cycle leave res_valid=1 holding the new product.
  - res_product is held while res_valid=1 && res_ready=0.
- Push and pop in the same cycle: level is unchanged. When the FIFO is full, in_ready=0 and in_valid is ignored.
- Arithmetic: full-precision signed product. The block never modifies the product.

## Timing
- Reset values: in_ready=1, mul_start=0, mul_a=0, mul_b=0, res_valid=0, res_product=0, busy=0, level=0, state=IDLE, FIFO pointers=0.
- Reset asserted mid-operation aborts immediately. The FIFO contents and any in-flight result are discarded. The multiplier is reset by the same rst.
- Issue latency: in_valid accepted at edge N gives pop at edge N+1 (ISSUE entered) and mul_start high during cycle N+1..N+2.
- Completion latency: res_valid rises on the edge after mul_ready is seen high in WAIT_DONE with the slot free.
- Back-to-back throughput is one operation per multiplier latency plus 3 cycles (IDLE, ISSUE, WAIT_BUSY minimum).
- mul_start is never asserted while the state is not ISSUE.

## Configuration
- MUL_ISSUE_ZERO_BYPASS_EN defined:
  - In IDLE, if the FIFO head has in_a==0 or in_b==0 and the result slot is free, the block pops the head and loads res_product=0, res_valid=1 in one cycle.
  - The state stays IDLE, the multiplier is not started, and ordering is preserved.
- MUL_ISSUE_ZERO_BYPASS_EN not defined: every pair goes through the multiplier.

## Test plan
- Reset: hold rst=0 for 3 cycles -> all outputs at their reset values; release -> in_ready=1, busy=0.
- Single op: push (12345, -1) with res_ready=1 -> exactly one mul_start pulse, res_valid pulses with res_product=-12345, level returns to 0.
- Backpressure and full: res_ready=0, push 5 pairs (3,4), (-7,2), (-1,1), (100,-100), (2,2) with DEPTH=4.
  - Required: in_ready falls when level=4, and the held res_product=12 stays until res_ready=1.
  - Required: the remaining results -14, -1, -10000, 4 follow in order.
- Zero operand: push (0, 12345).
  - Macro defined: res_product=0 with no mul_start pulse.
  - Macro undefined: res_product=0 after a full multiplier operation.
- Extremes: push (-32768, -32768) -> 1073741824; push (-32768, 32767) -> -1073709056.
- Reset mid-op: assert rst during WAIT_DONE with 2 pairs queued -> after release level=0, res_valid=0, and no further mul_start.
